// File: rtl/ltssm_polling_ctrl_if.sv
// Polling controller handshake: launch/lane-status inputs from the top-level LTSSM
// and RX qualifiers in, ordered-set transmit request and outcome pulses out.
interface ltssm_polling_ctrl_if #(
    parameter int NUM_LANES = 1
);
    logic                 start_i;
    logic [NUM_LANES-1:0] lane_detected_i;
    logic [NUM_LANES-1:0] rx_ts_valid_i;
    logic [NUM_LANES-1:0] rx_ts_is_ts2_i;
    logic [NUM_LANES-1:0] rx_ts_compl_i;
    logic [NUM_LANES-1:0] rx_os_bad_i;
    logic                 exit_compliance_i;
    logic                 os_ack_i;
    logic                 os_req_o;
    logic [1:0]           os_type_o;
    logic [NUM_LANES-1:0] lane_mask_o;
    logic [1:0]           state_o;
    logic                 done_o;
    logic                 to_detect_o;

    modport master (
        output start_i, lane_detected_i, rx_ts_valid_i, rx_ts_is_ts2_i,
               rx_ts_compl_i, rx_os_bad_i, exit_compliance_i, os_ack_i,
        input  os_req_o, os_type_o, lane_mask_o, state_o, done_o, to_detect_o
    );

    modport slave (
        input  start_i, lane_detected_i, rx_ts_valid_i, rx_ts_is_ts2_i,
               rx_ts_compl_i, rx_os_bad_i, exit_compliance_i, os_ack_i,
        output os_req_o, os_type_o, lane_mask_o, state_o, done_o, to_detect_o
    );
endinterface

// File: rtl/ltssm_polling_ctrl.sv
// LTSSM Polling sub-state controller: drives TS1 / compliance / TS2 transmission
// and qualifies per-lane received training sets to pick CONFIGURATION or DETECT.
module ltssm_polling_lane #(
    parameter int RX_CONSEC = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic inc_i,
    input  logic zap_i,
    output logic ok_o
);
    localparam int CW = $clog2(RX_CONSEC + 1);
    localparam logic [CW-1:0] CAP = CW'(RX_CONSEC);

    logic [CW-1:0] cnt_q;

    // A bad set in the same cycle as a valid one breaks the run.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                  cnt_q <= '0;
        else if (clr_i || zap_i)      cnt_q <= '0;
        else if (inc_i && cnt_q < CAP) cnt_q <= cnt_q + CW'(1);
    end

    assign ok_o = (cnt_q >= CAP);
endmodule

module ltssm_polling_ctrl #(
    parameter int NUM_LANES           = 1,
    parameter int TX_TS1_MIN          = 1024,
    parameter int TX_TS2_MIN          = 16,
    parameter int RX_CONSEC           = 8,
    parameter int POLL_TIMEOUT_CYCLES = 6000000,
    parameter int CFG_TIMEOUT_CYCLES  = 12000000
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    ltssm_polling_ctrl_if.slave bus
);
    localparam int TMAX = (POLL_TIMEOUT_CYCLES > CFG_TIMEOUT_CYCLES) ?
                          POLL_TIMEOUT_CYCLES : CFG_TIMEOUT_CYCLES;
    localparam int TW   = $clog2(TMAX) + 1;
    localparam int XMAX = (TX_TS1_MIN > TX_TS2_MIN) ? TX_TS1_MIN : TX_TS2_MIN;
    localparam int XW   = $clog2(XMAX + 1);

    localparam logic [TW-1:0] POLL_LAST = TW'(POLL_TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] CFG_LAST  = TW'(CFG_TIMEOUT_CYCLES - 1);
    localparam logic [XW-1:0] TS1_CAP   = XW'(TX_TS1_MIN);
    localparam logic [XW-1:0] TS2_CAP   = XW'(TX_TS2_MIN);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_COMPL  = 2'd2,
        S_CONFIG = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [NUM_LANES-1:0] mask_q, mask_d;
    logic                 done_d, todet_d;
    logic                 os_req_q, done_q, todet_q;
    logic [1:0]           os_type_q, os_type_d;
    logic [TW-1:0]        timer_q;
    logic [XW-1:0]        tx_q, tx_cap;
    logic                 compl_q, ts2_q;
    logic                 clr, ack_cnt, all_ok, any_ok;
    logic [NUM_LANES-1:0] lane_ok, inc, zap, vld_m;

    // Unmasked lanes never block success and never count toward it.
    assign all_ok = &(lane_ok | ~mask_q);
    assign any_ok = |(lane_ok & mask_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        done_d  = 1'b0;
        todet_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    mask_d = bus.lane_detected_i;
                    if (bus.lane_detected_i == '0) todet_d = 1'b1;
                    else                           state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (tx_q >= TS1_CAP && all_ok) begin
                    state_d = S_CONFIG;
                end else if (timer_q == POLL_LAST) begin
                    if (any_ok)       state_d = S_CONFIG;
                    else if (compl_q) state_d = S_COMPL;
                    else begin
                        state_d = S_IDLE;
                        todet_d = 1'b1;
                    end
                end
            end
            S_COMPL: begin
                if (bus.exit_compliance_i) state_d = S_ACTIVE;
            end
            S_CONFIG: begin
                if (all_ok && tx_q >= TS2_CAP) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (timer_q == CFG_LAST) begin
                    state_d = S_IDLE;
                    todet_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        os_type_d = 2'd0;
        case (state_d)
            S_ACTIVE: os_type_d = 2'd1;
            S_COMPL:  os_type_d = 2'd3;
            S_CONFIG: os_type_d = 2'd2;
            default:  os_type_d = 2'd0;
        endcase
    end

    // Every state entry starts timer, tx count, lane runs and flags from zero.
    assign clr     = (state_d != state_q) || (state_d == S_IDLE);
    assign tx_cap  = (state_q == S_CONFIG) ? TS2_CAP : TS1_CAP;
    assign ack_cnt = os_req_q && bus.os_ack_i &&
                     ((state_q == S_ACTIVE) || (state_q == S_CONFIG && ts2_q));

    always_comb begin
        vld_m = bus.rx_ts_valid_i & mask_q;
        inc   = '0;
        zap   = '0;
        if (state_q == S_ACTIVE) begin
            inc = vld_m;
            zap = bus.rx_os_bad_i & mask_q;
        end else if (state_q == S_CONFIG) begin
            // Only an unbroken TS2 run qualifies in Configuration.
            inc = vld_m & bus.rx_ts_is_ts2_i;
            zap = (bus.rx_os_bad_i & mask_q) | (vld_m & ~bus.rx_ts_is_ts2_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mask_q    <= '0;
            os_req_q  <= 1'b0;
            os_type_q <= 2'd0;
            done_q    <= 1'b0;
            todet_q   <= 1'b0;
            timer_q   <= '0;
            tx_q      <= '0;
            compl_q   <= 1'b0;
            ts2_q     <= 1'b0;
        end else begin
            mask_q    <= mask_d;
            os_req_q  <= (state_d != S_IDLE);
            os_type_q <= os_type_d;
            done_q    <= done_d;
            todet_q   <= todet_d;
            if (clr) begin
                timer_q <= '0;
                tx_q    <= '0;
                compl_q <= 1'b0;
                ts2_q   <= 1'b0;
            end else begin
                if (timer_q != '1) timer_q <= timer_q + TW'(1);
                if (ack_cnt && tx_q < tx_cap) tx_q <= tx_q + XW'(1);
                if (state_q == S_ACTIVE && |(vld_m & bus.rx_ts_compl_i)) compl_q <= 1'b1;
                if (state_q == S_CONFIG && |(vld_m & bus.rx_ts_is_ts2_i)) ts2_q <= 1'b1;
            end
        end
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        ltssm_polling_lane #(.RX_CONSEC(RX_CONSEC)) u_lane (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .clr_i  (clr),
            .inc_i  (inc[l]),
            .zap_i  (zap[l]),
            .ok_o   (lane_ok[l])
        );
    end

    assign bus.os_req_o    = os_req_q;
    assign bus.os_type_o   = os_type_q;
    assign bus.lane_mask_o = mask_q;
    assign bus.state_o     = state_q;
    assign bus.done_o      = done_q;
    assign bus.to_detect_o = todet_q;
endmodule

// File: tb/tb_ltssm_polling_ctrl.sv
// Directed + randomized bench for ltssm_polling_ctrl with a per-cycle reference model.
module tb_ltssm_polling_ctrl;
    localparam int NL   = 2;
    localparam int TS1N = 16;
    localparam int TS2N = 16;
    localparam int RXC  = 8;
    localparam int PTO  = 200;
    localparam int CTO  = 400;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b1;

    ltssm_polling_ctrl_if #(.NUM_LANES(NL)) bus ();

    ltssm_polling_ctrl #(
        .NUM_LANES(NL), .TX_TS1_MIN(TS1N), .TX_TS2_MIN(TS2N), .RX_CONSEC(RXC),
        .POLL_TIMEOUT_CYCLES(PTO), .CFG_TIMEOUT_CYCLES(CTO)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;

    // Reference model: phase 0 idle, 1 active, 2 compliance, 3 config.
    int            m_st, m_timer, m_tx;
    int            m_rx [NL];
    bit            m_compl, m_ts2, m_done, m_todet;
    logic [NL-1:0] m_mask;

    int            first_a, first_b, n_a, n_b;
    logic          seen;
    logic [NL-1:0] rv, rt, rc, rb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_timer = 0; m_tx = 0; m_compl = 0; m_ts2 = 0;
        m_done = 0; m_todet = 0; m_mask = '0;
        for (int l = 0; l < NL; l++) m_rx[l] = 0;
    endtask

    task automatic model_update();
        int nst;
        bit nd, ntd, all_ok, any_ok, v, t, c, b;
        if (!rst_ni) begin
            model_reset();
            return;
        end
        nst = m_st; nd = 0; ntd = 0; all_ok = 1; any_ok = 0;
        for (int l = 0; l < NL; l++)
            if (m_mask[l]) begin
                if (m_rx[l] >= RXC) any_ok = 1;
                else                all_ok = 0;
            end
        case (m_st)
            0: if (bus.start_i) begin
                   m_mask = bus.lane_detected_i;
                   if (bus.lane_detected_i == '0) ntd = 1;
                   else                           nst = 1;
               end
            1: if (m_tx >= TS1N && all_ok) nst = 3;
               else if (m_timer == PTO - 1) begin
                   if (any_ok)       nst = 3;
                   else if (m_compl) nst = 2;
                   else begin nst = 0; ntd = 1; end
               end
            2: if (bus.exit_compliance_i) nst = 1;
            default:
               if (all_ok && m_tx >= TS2N) begin nst = 0; nd = 1; end
               else if (m_timer == CTO - 1) begin nst = 0; ntd = 1; end
        endcase
        if (nst != m_st || nst == 0) begin
            m_timer = 0; m_tx = 0; m_compl = 0; m_ts2 = 0;
            for (int l = 0; l < NL; l++) m_rx[l] = 0;
        end else begin
            m_timer++;
            if (m_st == 1 && bus.os_ack_i && m_tx < TS1N) m_tx++;
            if (m_st == 3 && m_ts2 && bus.os_ack_i && m_tx < TS2N) m_tx++;
            for (int l = 0; l < NL; l++) begin
                v = bus.rx_ts_valid_i[l] & m_mask[l];
                t = bus.rx_ts_is_ts2_i[l];
                c = bus.rx_ts_compl_i[l];
                b = bus.rx_os_bad_i[l] & m_mask[l];
                if (m_st == 1) begin
                    if (b)      m_rx[l] = 0;
                    else if (v) m_rx[l] = (m_rx[l] + 1 > RXC) ? RXC : m_rx[l] + 1;
                    if (v && c) m_compl = 1;
                end else if (m_st == 3) begin
                    if (b || (v && !t)) m_rx[l] = 0;
                    else if (v)         m_rx[l] = (m_rx[l] + 1 > RXC) ? RXC : m_rx[l] + 1;
                    if (v && t) m_ts2 = 1;
                end
            end
        end
        m_st = nst; m_done = nd; m_todet = ntd;
    endtask

    function automatic logic [8:0] dut_outs();
        return {bus.os_req_o, bus.os_type_o, bus.lane_mask_o, bus.state_o,
                bus.done_o, bus.to_detect_o};
    endfunction

    function automatic logic [8:0] mdl_outs();
        logic [1:0] ty;
        logic       req;
        req = (m_st != 0);
        case (m_st)
            1:       ty = 2'd1;
            2:       ty = 2'd3;
            3:       ty = 2'd2;
            default: ty = 2'd0;
        endcase
        return {req, ty, m_mask, 2'(m_st), m_done, m_todet};
    endfunction

    task automatic step();
        @(posedge clk_i);
        model_update();
        #1;
        chk("outs", 32'(dut_outs()), 32'(mdl_outs()));
    endtask

    task automatic lanes(input logic [NL-1:0] v, input logic [NL-1:0] t,
                         input logic [NL-1:0] c, input logic [NL-1:0] b);
        bus.rx_ts_valid_i  = v;
        bus.rx_ts_is_ts2_i = t;
        bus.rx_ts_compl_i  = c;
        bus.rx_os_bad_i    = b;
    endtask

    task automatic launch(input logic [NL-1:0] det);
        bus.lane_detected_i = det;
        bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
    endtask

    initial begin
        bus.start_i = 1'b0; bus.lane_detected_i = '0; bus.exit_compliance_i = 1'b0;
        bus.os_ack_i = 1'b0;
        lanes('0, '0, '0, '0);
        #1 rst_ni = 1'b0;
        #1 model_reset();
        chk("reset_outs", 32'(dut_outs()), 32'(mdl_outs()));
        chk("reset_state", 32'(bus.state_o), 0);
        step(); step();
        #2 rst_ni = 1'b1;

        // Full success: 16 acks in Active, then 16 acks past the first TS2.
        launch(2'b11);
        first_a = -1; first_b = -1; n_b = 0;
        for (int i = 1; i <= 60; i++) begin
            bus.os_ack_i = 1'b1;
            lanes(2'b11, (i > 8) ? 2'b11 : 2'b00, 2'b00, 2'b00);
            step();
            if (bus.state_o == 2'd3 && first_a < 0) first_a = i;
            if (bus.done_o) begin
                n_b++;
                if (first_b < 0) first_b = i;
            end
        end
        chk("s1_cfg_edge", first_a, 17);
        chk("s1_done_edge", first_b, 35);
        chk("s1_done_count", n_b, 1);
        chk("s1_idle", 32'(bus.state_o), 0);
        bus.os_ack_i = 1'b0;
        lanes('0, '0, '0, '0);

        // No lanes detected: immediate failure, no transmission.
        launch(2'b00);
        chk("s2_todet", 32'(bus.to_detect_o), 1);
        chk("s2_state", 32'(bus.state_o), 0);
        seen = bus.os_req_o;
        step();
        chk("s2_pulse_once", 32'(bus.to_detect_o), 0);
        for (int i = 0; i < 5; i++) begin
            step();
            seen = seen | bus.os_req_o;
        end
        chk("s2_no_req", 32'(seen), 0);

        // One lane qualifies, the other is silent: partial-lane timeout to Config,
        // then Config times out with no TS2.
        launch(2'b11);
        first_a = -1;
        for (int i = 1; i <= 250 && first_a < 0; i++) begin
            bus.os_ack_i = 1'($urandom_range(0, 1));
            lanes((i <= 8) ? 2'b01 : 2'b00, 2'b00, 2'b00, 2'b00);
            step();
            if (bus.state_o == 2'd3) first_a = i;
        end
        chk("s3_partial_cfg", first_a, PTO);
        first_b = -1;
        for (int i = 1; i <= 450 && first_b < 0; i++) begin
            bus.os_ack_i = 1'($urandom_range(0, 1));
            rv = NL'($urandom);
            lanes(rv, 2'b00, 2'b00, 2'b00);
            step();
            if (bus.to_detect_o) first_b = i;
        end
        chk("s3_cfg_timeout", first_b, CTO);
        chk("s3_idle", 32'(bus.state_o), 0);

        // Broken run with compliance bit -> Compliance; lane 1 is unmasked junk.
        launch(2'b01);
        first_a = -1;
        for (int i = 1; i <= 250 && first_a < 0; i++) begin
            bus.os_ack_i = 1'b1;
            rv = {1'($urandom), ((i <= 7) || (i >= 9 && i <= 15)) ? 1'b1 : 1'b0};
            rt = {1'($urandom), 1'b0};
            rc = {1'($urandom), 1'b1};
            rb = {1'($urandom), (i == 8) ? 1'b1 : 1'b0};
            lanes(rv, rt, rc, rb);
            step();
            if (bus.state_o == 2'd2) first_a = i;
        end
        chk("s4_compliance", first_a, PTO);
        chk("s4_type3", 32'(bus.os_type_o), 3);
        for (int i = 0; i < 300; i++) begin
            rv = NL'($urandom); rt = NL'($urandom); rc = NL'($urandom);
            lanes(rv, rt, rc, 2'b00);
            step();
        end
        chk("s4_compl_hold", 32'(bus.state_o), 2);
        bus.exit_compliance_i = 1'b1;
        step();
        bus.exit_compliance_i = 1'b0;
        chk("s4_exit_state", 32'(bus.state_o), 1);
        chk("s4_exit_type", 32'(bus.os_type_o), 1);
        first_b = -1;
        for (int i = 1; i <= 250 && first_b < 0; i++) begin
            bus.start_i = (i == 50);
            bus.lane_detected_i = 2'b11;
            rv = {1'($urandom), ((i <= 7) || (i >= 9 && i <= 15)) ? 1'b1 : 1'b0};
            rc = {1'($urandom), 1'b0};
            rb = {1'b0, (i == 8) ? 1'b1 : 1'b0};
            lanes(rv, 2'b00, rc, rb);
            step();
            if (i == 50) chk("s4_start_ignored", 32'(bus.lane_mask_o), 32'h1);
            if (bus.to_detect_o) first_b = i;
        end
        bus.start_i = 1'b0;
        chk("s4_no_compl_todet", first_b, PTO);

        // Config success lands on the same cycle as the Config timeout.
        launch(2'b11);
        first_a = -1;
        for (int i = 1; i <= 30 && first_a < 0; i++) begin
            bus.os_ack_i = 1'b1;
            lanes(2'b11, (i > 8) ? 2'b11 : 2'b00, 2'b00, 2'b00);
            step();
            if (bus.state_o == 2'd3) first_a = i;
        end
        chk("s6_cfg", first_a, 17);
        first_b = -1; n_a = 0;
        for (int i = 1; i <= 420 && first_b < 0 && n_a == 0; i++) begin
            bus.os_ack_i = (i >= 384 && i <= 399);
            lanes(2'b11, 2'b11, 2'b00, 2'b00);
            step();
            if (bus.done_o) first_b = i;
            if (bus.to_detect_o) n_a++;
        end
        chk("s6_done_edge", first_b, CTO);
        chk("s6_no_todet", n_a, 0);

        // Async reset while in Config.
        launch(2'b11);
        first_a = -1;
        for (int i = 1; i <= 30 && first_a < 0; i++) begin
            bus.os_ack_i = 1'b1;
            lanes(2'b11, (i > 8) ? 2'b11 : 2'b00, 2'b00, 2'b00);
            step();
            if (bus.state_o == 2'd3) first_a = i;
        end
        for (int i = 0; i < 5; i++) step();
        chk("s7_in_cfg", 32'(bus.state_o), 3);
        #2 rst_ni = 1'b0;
        #1 model_reset();
        chk("s7_async_reset", 32'(dut_outs()), 0);
        step(); step();
        #2 rst_ni = 1'b1;
        bus.os_ack_i = 1'b0;
        lanes('0, '0, '0, '0);

        // Random soak against the model.
        for (int n = 0; n < 3000; n++) begin
            bus.start_i = ($urandom_range(0, 15) == 0);
            bus.lane_detected_i = NL'($urandom);
            bus.os_ack_i = ($urandom_range(0, 9) < 8);
            bus.exit_compliance_i = ($urandom_range(0, 19) == 0);
            for (int l = 0; l < NL; l++) begin
                rv[l] = ($urandom_range(0, 9) < 9);
                rt[l] = (m_st == 3) ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 1) == 1);
                rc[l] = ($urandom_range(0, 9) == 0);
                rb[l] = ($urandom_range(0, 49) == 0);
            end
            lanes(rv, rt, rc, rb);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
